tick_scheduler: RTL
===================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter MAX, default 50000000: prescaler reload value; base tick period is MAX+1 clocks.
REQ-002 Parameter N_CH, default 4: number of requester channels (Pac-Man plus ghosts); legal range 2..8.
REQ-003 Parameter DIV_W, default 4: width of each channel divider.
REQ-004 CLOCK_50  input  1  sole clock, all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  pulse; IDLE -> RUN.
REQ-007 stop  input  1  pulse; any state -> IDLE.
REQ-008 pause  input  1  level; RUN <-> PAUSED.
REQ-009 cfg_valid  input  1  config write request.
REQ-010 cfg_ready  output  1  config write accepted this cycle when high with cfg_valid.
REQ-011 cfg_ch  input  $clog2(N_CH)  target channel.
REQ-012 cfg_div  input  DIV_W  channel divider; 0 disables channel.
REQ-013 base_tick  output  1  one-cycle pulse at prescaler terminal count.
REQ-014 grant  output  N_CH  registered one-hot move grant; at most one bit high per cycle.
REQ-015 state  output  2  00 IDLE, 01 RUN, 10 PAUSED.
REQ-016 overrun  output  N_CH  sticky per-channel missed-grant flags.

Function
REQ-017 FSM: IDLE -start-> RUN; RUN -pause=1-> PAUSED; PAUSED -pause=0-> RUN; stop -> IDLE from any state; stop has priority over start and pause.
REQ-018 Prescaler: width $clog2(MAX+1); in RUN decrements by 1, at 0 asserts base_tick for one cycle and reloads MAX; held at MAX in IDLE; frozen in PAUSED.
REQ-019 First base_tick occurs MAX+1 clocks after the edge entering RUN.
REQ-020 Per channel: div_reg and dcnt; on base_tick with div_reg!=0: dcnt==1 -> set pending, dcnt<=div_reg; else dcnt-1; div_reg==0 never sets pending.
REQ-021 Arbiter: in RUN, if any pending, grant lowest-index pending channel at or after rr_ptr (cyclic); grant registered next edge, that pending cleared same edge, rr_ptr <= granted index+1 mod N_CH.
REQ-022 No grants in IDLE or PAUSED; pendings retained across PAUSED, cleared on entering IDLE.
REQ-023 Expiry on a channel whose pending is being cleared by grant on the same edge: pending stays set, no overrun.
REQ-024 Expiry on a channel already pending and not granted that edge: overrun bit set, pending stays set.
REQ-025 cfg_ready = 1 only in IDLE or PAUSED; accepted write loads div_reg[cfg_ch]<=cfg_div and dcnt<=cfg_div.
REQ-026 cfg_ch >= N_CH: write accepted and discarded.
REQ-027 stop clears overrun, pending, rr_ptr, reloads prescaler to MAX and every dcnt to its div_reg; div_reg retained.

Reset
REQ-028 reset_n low asynchronously forces: state IDLE, prescaler MAX, every div_reg and dcnt 1, pending 0, rr_ptr 0, grant 0, base_tick 0, overrun 0.
REQ-029 Reset mid-RUN drops any in-flight grant immediately; no grant in the first clock after release.

Configuration
REQ-030 Macro TICK_SCHEDULER_OVERRUN_EN defined: REQ-024 logic present, overrun reported.
REQ-031 Macro undefined: overrun tied to 0, no overrun registers; all other behaviour identical.

Verification (MAX=3, N_CH=4, DIV_W=4)
REQ-032 Reset release, start pulse -> base_tick on clocks 4, 8, 12 after RUN entry; grant to ch0..ch3 on consecutive cycles after each base_tick (div all 1).
REQ-033 In IDLE write ch2 div=3, ch1 div=0, start -> ch1 never granted; ch2 granted after every 3rd base_tick only.
REQ-034 pause asserted 2 clocks into RUN for 10 clocks -> state=10, no base_tick/grant, cfg_ready=1; release -> base_tick 2 clocks after resume.
REQ-035 MAX=0, div all 1, macro defined -> every channel expires each cycle, only one granted per cycle, overrun goes 1111 within 4 clocks; stop -> overrun 0000, state IDLE.
REQ-036 start and stop same cycle -> state stays IDLE; reset_n low mid-grant -> grant 0 same cycle, state IDLE.

Source files
------------

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: channel-divider configuration handshake for tick_scheduler.
//   cfg_valid  master->slave  write request
//   cfg_ready  slave->master  write accepted when high together with cfg_valid
//   cfg_ch     master->slave  target channel index
//   cfg_div    master->slave  channel divider (0 disables the channel)
interface tick_scheduler_if #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned DIV_W = 4
) ();
   localparam int unsigned CH_W = $clog2(N_CH);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;

   modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready);
   modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready);
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler: game-tick prescaler with per-channel dividers and a round-robin
// move-grant arbiter (Pac-Man plus ghosts).
//   CLOCK_50   in   sole clock
//   reset_n    in   asynchronous active-low reset
//   start      in   pulse, IDLE -> RUN
//   stop       in   pulse, any state -> IDLE (highest priority)
//   pause      in   level, RUN <-> PAUSED
//   cfg        slave modport of tick_scheduler_if (divider writes, IDLE/PAUSED only)
//   base_tick  out  one-cycle pulse at prescaler terminal count
//   grant      out  registered one-hot move grant
//   state      out  00 IDLE, 01 RUN, 10 PAUSED
//   overrun    out  sticky per-channel missed-grant flags
// Optional feature: define TICK_SCHEDULER_OVERRUN_EN to build the overrun flags;
// otherwise overrun is tied to zero.
module tick_scheduler #(
   parameter int unsigned MAX   = 50000000,
   parameter int unsigned N_CH  = 4,
   parameter int unsigned DIV_W = 4
) (
   input  logic            CLOCK_50,
   input  logic            reset_n,
   input  logic            start,
   input  logic            stop,
   input  logic            pause,
   tick_scheduler_if.slave cfg,
   output logic            base_tick,
   output logic [N_CH-1:0] grant,
   output logic [1:0]      state,
   output logic [N_CH-1:0] overrun
);
   localparam int unsigned CH_W = $clog2(N_CH);
   // MAX=0 would give a zero-width prescaler; keep at least one bit
   localparam int unsigned PW   = (MAX > 0) ? $clog2(MAX + 1) : 1;
   localparam logic [PW-1:0] MAX_P = PW'(MAX);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_PAUSED = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic              cfg_ready_q;
   logic [PW-1:0]     presc_q;
   logic [N_CH-1:0]   pending_q;
   logic [CH_W-1:0]   rr_q;
   logic [DIV_W-1:0]  div_q  [N_CH];
   logic [DIV_W-1:0]  dcnt_q [N_CH];
   logic [DIV_W-1:0]  dcnt_d [N_CH];
   logic [N_CH-1:0]   expire;
   logic [N_CH-1:0]   gnt_oh;
   logic [CH_W-1:0]   gnt_idx;
   logic [CH_W-1:0]   rr_next;
   logic              gnt_any;
   logic              run_go;
   logic              tc;
   logic              cfg_acc;

   // Next-state logic; stop dominates start and pause
   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (start)  state_d = S_RUN;
            S_RUN:    if (pause)  state_d = S_PAUSED;
            S_PAUSED: if (!pause) state_d = S_RUN;
            default:              state_d = S_IDLE;
         endcase
      end
   end

   // Scheduler only advances on edges that stay in RUN, so the edge that
   // leaves RUN neither ticks nor grants and the resume edge is a hold cycle
   assign run_go  = (state_q == S_RUN) && (state_d == S_RUN);
   assign tc      = run_go && (presc_q == '0);
   assign cfg_acc = cfg.cfg_valid && cfg_ready_q && (32'(cfg.cfg_ch) < N_CH);

   // Round-robin pick: first pending channel at or after rr_q
   always_comb begin
      logic [CH_W-1:0] cand;
      cand    = '0;
      gnt_oh  = '0;
      gnt_idx = rr_q;
      gnt_any = 1'b0;
      if (run_go) begin
         for (int unsigned k = 0; k < N_CH; k++) begin
            cand = CH_W'((32'(rr_q) + k) % N_CH);
            if (!gnt_any && pending_q[cand]) begin
               gnt_any = 1'b1;
               gnt_idx = cand;
            end
         end
      end
      if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
      rr_next = CH_W'((32'(gnt_idx) + 32'd1) % N_CH);
   end

   // Channel dividers count base ticks; a zero divider never expires
   always_comb begin
      expire = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         dcnt_d[c] = dcnt_q[c];
         if (tc && (div_q[c] != '0)) begin
            if (dcnt_q[c] == DIV_W'(1)) begin
               expire[c] = 1'b1;
               dcnt_d[c] = div_q[c];
            end else begin
               dcnt_d[c] = dcnt_q[c] - DIV_W'(1);
            end
         end
      end
   end

   // State, prescaler, pending, arbiter pointer and divider registers
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cfg_ready_q <= 1'b1;
         presc_q     <= MAX_P;
         pending_q   <= '0;
         rr_q        <= '0;
         grant       <= '0;
         base_tick   <= 1'b0;
         for (int unsigned c = 0; c < N_CH; c++) begin
            div_q[c]  <= DIV_W'(1);
            dcnt_q[c] <= DIV_W'(1);
         end
      end else begin
         state_q     <= state_d;
         cfg_ready_q <= (state_d != S_RUN);
         base_tick   <= tc;
         grant       <= gnt_oh;
         if (stop) begin
            presc_q   <= MAX_P;
            pending_q <= '0;
            rr_q      <= '0;
            for (int unsigned c = 0; c < N_CH; c++) dcnt_q[c] <= div_q[c];
         end else begin
            if (state_q == S_IDLE) presc_q <= MAX_P;
            else if (run_go)       presc_q <= (presc_q == '0) ? MAX_P : presc_q - PW'(1);
            // A grant and an expiry on the same channel leave it pending
            pending_q <= (pending_q & ~gnt_oh) | expire;
            if (gnt_any) rr_q <= rr_next;
            for (int unsigned c = 0; c < N_CH; c++) dcnt_q[c] <= dcnt_d[c];
         end
         // Config write overrides the stop reload of the same channel
         if (cfg_acc) begin
            div_q[cfg.cfg_ch]  <= cfg.cfg_div;
            dcnt_q[cfg.cfg_ch] <= cfg.cfg_div;
         end
      end
   end

   assign cfg.cfg_ready = cfg_ready_q;
   assign state         = state_q;

`ifdef TICK_SCHEDULER_OVERRUN_EN
   logic [N_CH-1:0] overrun_q;

   // Expiry on a channel still waiting for its previous grant
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n)  overrun_q <= '0;
      else if (stop) overrun_q <= '0;
      else           overrun_q <= overrun_q | (expire & pending_q & ~gnt_oh);
   end

   assign overrun = overrun_q;
`else
   assign overrun = '0;
`endif

endmodule
